// File: rtl/string_receiver.sv
// WS2812B-format single-wire receiver: measures high pulses to recover bits, assembles
// 24-bit pixels MSB first, and detects the long-low frame reset.
module string_receiver #(
  parameter int unsigned ClkPeriodNs = 100,
  parameter int unsigned ResetNs     = 50000,
  parameter int unsigned IdxW        = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            sdi_i,
  output logic [23:0]     pixel_data_o,
  output logic            pixel_valid_o,
  output logic [IdxW-1:0] pixel_index_o,
  output logic            frame_sync_o,
  output logic            synced_o,
  output logic            bit_err_o
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] MinHigh    = CntW'((150 + ClkPeriodNs - 1) / ClkPeriodNs);
  localparam logic [CntW-1:0] Thresh     = CntW'((600 + ClkPeriodNs - 1) / ClkPeriodNs);
  localparam logic [CntW-1:0] MaxHigh    = CntW'((2000 + ClkPeriodNs - 1) / ClkPeriodNs);
  localparam logic [CntW-1:0] ResetCount = CntW'((ResetNs + ClkPeriodNs - 1) / ClkPeriodNs);

  typedef enum logic {StLow, StHigh} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sdi_s_q, sdi_d_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [23:0]       pixel_data_q, pixel_data_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [IdxW-1:0]   pixel_index_q, pixel_index_d;
  logic              frame_sync_q, frame_sync_d;
  logic              synced_q, synced_d;
  logic              bit_err_q, bit_err_d;

  logic rise, frame_evt, pulse_evt, pulse_ok, bit_val;

  assign rise      = sdi_s_q & ~sdi_d_q;
  assign frame_evt = (state_q == StLow) && (cnt_q == ResetCount);
  assign pulse_evt = (state_q == StHigh) && !sdi_s_q;
  assign pulse_ok  = (cnt_q >= MinHigh) && (cnt_q <= MaxHigh);
  assign bit_val   = (cnt_q >= Thresh);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StLow;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLow:   if (rise) state_d = StHigh;
      StHigh:  if (!sdi_s_q) state_d = StLow;
      default: state_d = StLow;
    endcase
  end

  // Run counter, bit assembly and output strobes
  always_comb begin
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index_q;
    frame_sync_d  = 1'b0;
    synced_d      = synced_q;
    bit_err_d     = 1'b0;

    if (state_q == StLow) begin
      if (rise) begin
        cnt_d = CntW'(1);
      end else if (!sdi_s_q && cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (!sdi_s_q) begin
        cnt_d = CntW'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // The counter passes ResetCount only once per low run, so this fires once.
    if (frame_evt) begin
      frame_sync_d  = 1'b1;
      synced_d      = 1'b1;
      idx_d         = '0;
      pixel_index_d = '0;
      if (bit_cnt_q != '0) begin
        bit_err_d = 1'b1;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
    end

    if (pulse_evt && synced_q) begin
      if (!pulse_ok) begin
        bit_err_d = 1'b1;
      end else begin
        shift_d = {shift_q[22:0], bit_val};
        if (bit_cnt_q == 5'd23) begin
          pixel_data_d  = {shift_q[22:0], bit_val};
          pixel_valid_d = 1'b1;
          pixel_index_d = idx_q;
          idx_d         = idx_q + 1'b1;
          bit_cnt_d     = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q       <= 1'b0;
      sdi_s_q       <= 1'b0;
      sdi_d_q       <= 1'b0;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      idx_q         <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      frame_sync_q  <= 1'b0;
      synced_q      <= 1'b0;
      bit_err_q     <= 1'b0;
    end else begin
      sync1_q       <= sdi_i;
      sdi_s_q       <= sync1_q;
      sdi_d_q       <= sdi_s_q;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      frame_sync_q  <= frame_sync_d;
      synced_q      <= synced_d;
      bit_err_q     <= bit_err_d;
    end
  end

  assign pixel_data_o  = pixel_data_q;
  assign pixel_valid_o = pixel_valid_q;
  assign pixel_index_o = pixel_index_q;
  assign frame_sync_o  = frame_sync_q;
  assign synced_o      = synced_q;
  assign bit_err_o     = bit_err_q;

endmodule
